// File: rtl/rep_seq_ctrl_pkg.sv
// Shared definitions for the REP string-instruction sequencer: state codes,
// prefix kinds, operand sizes and the operand-size to byte-step mapping.
package rep_seq_ctrl_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] KIND_REP   = 2'd0;
  localparam logic [1:0] KIND_REPE  = 2'd1;
  localparam logic [1:0] KIND_REPNE = 2'd2;
  localparam logic [1:0] KIND_RSVD  = 2'd3;

  localparam logic [1:0] OP_8  = 2'd0;
  localparam logic [1:0] OP_16 = 2'd1;
  localparam logic [1:0] OP_32 = 2'd2;
  localparam logic [1:0] OP_64 = 2'd3;

  localparam int unsigned STEP_W = 4;

  // Byte step per iteration: 1 << opsize
  function automatic logic [STEP_W-1:0] step_of(input logic [1:0] opsize);
    logic [STEP_W-1:0] s;
    case (opsize)
      OP_8:    s = 4'd1;
      OP_16:   s = 4'd2;
      OP_32:   s = 4'd4;
      OP_64:   s = 4'd8;
      default: s = 4'd1;
    endcase
    return s;
  endfunction

  // REPE/REPNE honour early termination; REP and the reserved code do not
  function automatic logic is_cond_kind(input logic [1:0] kind);
    logic r;
    case (kind)
      KIND_REPE, KIND_REPNE: r = 1'b1;
      KIND_REP, KIND_RSVD:   r = 1'b0;
      default:               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rep_addr_step.sv
// Address stepper: next = addr +/- step, wrapping modulo 2^ADDR_W.
module rep_addr_step
  import rep_seq_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [STEP_W-1:0] step,
  input  logic              dec,
  output logic [ADDR_W-1:0] next_addr_c
);

  logic [ADDR_W-1:0] step_ext;

  assign step_ext    = ADDR_W'(step);
  assign next_addr_c = dec ? (addr - step_ext) : (addr + step_ext);

endmodule

// File: rtl/rep_seq_ctrl.sv
// REP string sequencer: owns ECX and the M1/M2 address steppers, issues one
// D$ iteration per advancing cycle and holds upstream until the REP completes.
module rep_seq_ctrl
  import rep_seq_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              valid_in,
  input  logic              is_rep_in,
  input  logic [1:0]        rep_kind,
  input  logic [1:0]        opsize_in,
  input  logic              df_in,
  input  logic [CNT_W-1:0]  count_in,
  input  logic [ADDR_W-1:0] mem_addr1_in,
  input  logic [ADDR_W-1:0] mem_addr2_in,
  input  logic              cache_stall,
  input  logic              fwd_stall,
  input  logic              term_req,
  output logic [ADDR_W-1:0] mem1_addr,
  output logic [ADDR_W-1:0] mem2_addr,
  output logic              iter_valid,
  output logic              last_iter,
  output logic [CNT_W-1:0]  count_out,
  output logic              stall_out,
  output logic              busy,
  output logic              skip
);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [ADDR_W-1:0] addr2_q, addr2_d;
  logic [1:0]        opsize_q, opsize_d;
  logic              df_q, df_d;
  logic [1:0]        kind_q, kind_d;

  logic              run;
  logic              adv;
  logic [ADDR_W-1:0] base1, base2;
  logic [ADDR_W-1:0] next1, next2;
  logic [STEP_W-1:0] step_sel;
  logic              dec_sel;
  logic              last_c;

  assign run = (state_q == ST_RUN);
  assign adv = ~cache_stall & ~fwd_stall;

  // In IDLE the steppers work on the incoming instruction, in RUN on the latched copy
  assign base1    = run ? addr1_q : mem_addr1_in;
  assign base2    = run ? addr2_q : mem_addr2_in;
  assign step_sel = run ? step_of(opsize_q) : step_of(opsize_in);
  assign dec_sel  = run ? df_q : df_in;

  rep_addr_step #(.ADDR_W(ADDR_W)) u_step_m1 (
    .addr        (base1),
    .step        (step_sel),
    .dec         (dec_sel),
    .next_addr_c (next1)
  );

  rep_addr_step #(.ADDR_W(ADDR_W)) u_step_m2 (
    .addr        (base2),
    .step        (step_sel),
    .dec         (dec_sel),
    .next_addr_c (next2)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      opsize_q <= '0;
      df_q     <= 1'b0;
      kind_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr1_q  <= addr1_d;
      addr2_q  <= addr2_d;
      opsize_q <= opsize_d;
      df_q     <= df_d;
      kind_q   <= kind_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr1_d    = addr1_q;
    addr2_d    = addr2_q;
    opsize_d   = opsize_q;
    df_d       = df_q;
    kind_d     = kind_q;
    mem1_addr  = '0;
    mem2_addr  = '0;
    iter_valid = 1'b0;
    last_iter  = 1'b0;
    count_out  = '0;
    stall_out  = 1'b0;
    busy       = 1'b0;
    skip       = 1'b0;
    last_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          if (!is_rep_in) begin
            mem1_addr  = mem_addr1_in;
            mem2_addr  = mem_addr2_in;
            iter_valid = 1'b1;
            last_iter  = 1'b1;
            count_out  = count_in;
          end else if (count_in == '0) begin
            skip = 1'b1;
          end else begin
            mem1_addr  = mem_addr1_in;
            mem2_addr  = mem_addr2_in;
            iter_valid = 1'b1;
            count_out  = count_in - CNT_W'(1);
            if (count_in == CNT_W'(1)) begin
              last_iter = 1'b1;
            end else begin
              stall_out = 1'b1;
              // Iteration 0 is re-presented until it is accepted
              if (adv) begin
                cnt_d    = count_in - CNT_W'(1);
                addr1_d  = next1;
                addr2_d  = next2;
                opsize_d = opsize_in;
                df_d     = df_in;
                kind_d   = rep_kind;
                state_d  = ST_RUN;
              end
            end
          end
        end
      end

      ST_RUN: begin
        mem1_addr  = addr1_q;
        mem2_addr  = addr2_q;
        iter_valid = 1'b1;
        busy       = 1'b1;
        count_out  = cnt_q - CNT_W'(1);
        last_c     = (cnt_q == CNT_W'(1)) | (term_req & is_cond_kind(kind_q));
        last_iter  = last_c;
        stall_out  = ~(last_c & adv);
        if (adv) begin
          cnt_d   = cnt_q - CNT_W'(1);
          addr1_d = next1;
          addr2_d = next2;
          if (last_c) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Reset forces every output low immediately, including IDLE pass-through
    if (!clr) begin
      mem1_addr  = '0;
      mem2_addr  = '0;
      iter_valid = 1'b0;
      last_iter  = 1'b0;
      count_out  = '0;
      stall_out  = 1'b0;
      busy       = 1'b0;
      skip       = 1'b0;
    end
  end

endmodule

// File: tb/tb_rep_seq_ctrl.sv
// Directed bench for rep_seq_ctrl with hand-computed per-cycle expectations.
module tb_rep_seq_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 32;

  logic              clk = 1'b0;
  logic              clr;
  logic              valid_in;
  logic              is_rep_in;
  logic [1:0]        rep_kind;
  logic [1:0]        opsize_in;
  logic              df_in;
  logic [CNT_W-1:0]  count_in;
  logic [ADDR_W-1:0] mem_addr1_in;
  logic [ADDR_W-1:0] mem_addr2_in;
  logic              cache_stall;
  logic              fwd_stall;
  logic              term_req;
  logic [ADDR_W-1:0] mem1_addr;
  logic [ADDR_W-1:0] mem2_addr;
  logic              iter_valid;
  logic              last_iter;
  logic [CNT_W-1:0]  count_out;
  logic              stall_out;
  logic              busy;
  logic              skip;

  int checks   = 0;
  int failures = 0;

  rep_seq_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .clr          (clr),
    .valid_in     (valid_in),
    .is_rep_in    (is_rep_in),
    .rep_kind     (rep_kind),
    .opsize_in    (opsize_in),
    .df_in        (df_in),
    .count_in     (count_in),
    .mem_addr1_in (mem_addr1_in),
    .mem_addr2_in (mem_addr2_in),
    .cache_stall  (cache_stall),
    .fwd_stall    (fwd_stall),
    .term_req     (term_req),
    .mem1_addr    (mem1_addr),
    .mem2_addr    (mem2_addr),
    .iter_valid   (iter_valid),
    .last_iter    (last_iter),
    .count_out    (count_out),
    .stall_out    (stall_out),
    .busy         (busy),
    .skip         (skip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in     = 1'b0;
    is_rep_in    = 1'b0;
    rep_kind     = 2'd0;
    opsize_in    = 2'd0;
    df_in        = 1'b0;
    count_in     = '0;
    mem_addr1_in = '0;
    mem_addr2_in = '0;
    cache_stall  = 1'b0;
    fwd_stall    = 1'b0;
    term_req     = 1'b0;
  endtask

  task automatic start(input logic rep, input logic [1:0] kind, input logic [1:0] op,
                       input logic df, input logic [31:0] cnt,
                       input logic [31:0] a1, input logic [31:0] a2);
    valid_in     = 1'b1;
    is_rep_in    = rep;
    rep_kind     = kind;
    opsize_in    = op;
    df_in        = df;
    count_in     = cnt;
    mem_addr1_in = a1;
    mem_addr2_in = a2;
  endtask

  initial begin
    logic [31:0] wrap_a1 [3];
    logic [31:0] wrap_a2 [3];
    logic        cs     [6];
    logic [31:0] st_a1  [6];
    logic [31:0] st_cnt [6];
    wrap_a1 = '{32'h1, 32'h0, 32'hFFFF_FFFF};
    wrap_a2 = '{32'h10, 32'hF, 32'hE};
    cs      = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    st_a1   = '{32'h100, 32'h102, 32'h104, 32'h104, 32'h104, 32'h106};
    st_cnt  = '{32'd3, 32'd2, 32'd1, 32'd1, 32'd1, 32'd0};

    // Reset with a live instruction on the inputs: everything must read 0
    idle_inputs();
    clr = 1'b0;
    start(1'b0, 2'd0, 2'd2, 1'b0, 32'd7, 32'h1000, 32'h5000);
    #2;
    check("rst_iter_valid", 64'(iter_valid), 64'd0);
    check("rst_mem1", 64'(mem1_addr), 64'h0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(count_out), 64'd0);
    #1 clr = 1'b1;

    // Non-REP pass-through
    tick();
    start(1'b0, 2'd0, 2'd2, 1'b0, 32'd7, 32'h1000, 32'h5000);
    #2;
    check("nrep_iter_valid", 64'(iter_valid), 64'd1);
    check("nrep_last", 64'(last_iter), 64'd1);
    check("nrep_mem1", 64'(mem1_addr), 64'h1000);
    check("nrep_mem2", 64'(mem2_addr), 64'h5000);
    check("nrep_stall", 64'(stall_out), 64'd0);
    check("nrep_count", 64'(count_out), 64'd7);

    // REP MOVSD, count 3, increment by 4
    tick();
    start(1'b1, 2'd0, 2'd2, 1'b0, 32'd3, 32'h2000, 32'h3000);
    for (int i = 0; i < 3; i++) begin
      #2;
      check($sformatf("movsd_mem1_%0d", i), 64'(mem1_addr), 64'(32'h2000 + 32'(4 * i)));
      check($sformatf("movsd_mem2_%0d", i), 64'(mem2_addr), 64'(32'h3000 + 32'(4 * i)));
      check($sformatf("movsd_cnt_%0d", i), 64'(count_out), 64'(2 - i));
      check($sformatf("movsd_last_%0d", i), 64'(last_iter), 64'(i == 2));
      check($sformatf("movsd_stall_%0d", i), 64'(stall_out), 64'(i != 2));
      check($sformatf("movsd_busy_%0d", i), 64'(busy), 64'(i != 0));
      tick();
      if (i == 0) idle_inputs();
    end
    #2;
    check("movsd_done_busy", 64'(busy), 64'd0);
    check("movsd_done_iv", 64'(iter_valid), 64'd0);

    // Decrementing byte REP wrapping below zero
    tick();
    start(1'b1, 2'd0, 2'd0, 1'b1, 32'd3, 32'h1, 32'h10);
    for (int i = 0; i < 3; i++) begin
      #2;
      check($sformatf("wrap_mem1_%0d", i), 64'(mem1_addr), 64'(wrap_a1[i]));
      check($sformatf("wrap_mem2_%0d", i), 64'(mem2_addr), 64'(wrap_a2[i]));
      tick();
      if (i == 0) idle_inputs();
    end

    // Cache stall for two cycles while iteration 2 of 4 is presented
    start(1'b1, 2'd0, 2'd1, 1'b0, 32'd4, 32'h100, 32'h200);
    for (int i = 0; i < 6; i++) begin
      cache_stall = cs[i];
      #2;
      check($sformatf("cstall_mem1_%0d", i), 64'(mem1_addr), 64'(st_a1[i]));
      check($sformatf("cstall_cnt_%0d", i), 64'(count_out), 64'(st_cnt[i]));
      check($sformatf("cstall_last_%0d", i), 64'(last_iter), 64'(i == 5));
      check($sformatf("cstall_stall_%0d", i), 64'(stall_out), 64'(i != 5));
      tick();
      if (i == 0) idle_inputs();
    end
    #2;
    check("cstall_done_busy", 64'(busy), 64'd0);

    // REPE count 10 terminated while iteration 3 is presented
    tick();
    start(1'b1, 2'd1, 2'd2, 1'b0, 32'd10, 32'h8000, 32'h9000);
    for (int i = 0; i < 4; i++) begin
      term_req = (i == 3);
      #2;
      check($sformatf("repe_cnt_%0d", i), 64'(count_out), 64'(9 - i));
      check($sformatf("repe_last_%0d", i), 64'(last_iter), 64'(i == 3));
      check($sformatf("repe_skip_%0d", i), 64'(skip), 64'd0);
      tick();
      if (i == 0) idle_inputs();
    end
    term_req = 1'b0;
    #2;
    check("repe_done_busy", 64'(busy), 64'd0);
    check("repe_done_iv", 64'(iter_valid), 64'd0);

    // REP with zero count retires as a no-op
    tick();
    start(1'b1, 2'd0, 2'd2, 1'b0, 32'd0, 32'hA000, 32'hB000);
    #2;
    check("zero_skip", 64'(skip), 64'd1);
    check("zero_iv", 64'(iter_valid), 64'd0);
    check("zero_stall", 64'(stall_out), 64'd0);
    tick();
    idle_inputs();
    #2;
    check("zero_busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of RUN
    tick();
    start(1'b1, 2'd0, 2'd2, 1'b0, 32'd5, 32'h4000, 32'h4100);
    #2;
    check("arst_pre_stall", 64'(stall_out), 64'd1);
    tick();
    #2;
    check("arst_run_busy", 64'(busy), 64'd1);
    check("arst_run_mem1", 64'(mem1_addr), 64'h4004);
    #1 clr = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_iv", 64'(iter_valid), 64'd0);
    check("arst_mem1", 64'(mem1_addr), 64'h0);
    check("arst_count", 64'(count_out), 64'd0);
    check("arst_stall", 64'(stall_out), 64'd0);
    #1 clr = 1'b1;
    idle_inputs();
    tick();
    #2;
    check("arst_after_busy", 64'(busy), 64'd0);
    check("arst_after_iv", 64'(iter_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
